// File: rtl/sdram_dl_writer.sv
// Packs a byte-wide download stream into 16-bit SDRAM writes through a small
// FIFO and drives a toggle req/ack port. Pulses done once the download is flushed.
module sdram_dl_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [22:0] ADDR_BASE  = 23'h0
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [23:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port_req,
  input  logic        port_ack,
  output logic        port_we,
  output logic [22:0] port_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {DL_IDLE, DL_ACTIVE, DL_FLUSH, DL_DONE} dl_state_t;
  typedef enum logic {RQ_IDLE, RQ_BUSY} rq_state_t;

  typedef struct packed {
    logic [22:0] addr;
    logic [1:0]  ds;
    logic [15:0] data;
  } entry_t;

  dl_state_t dl_state_q, dl_state_d;
  rq_state_t rq_state_q, rq_state_d;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;

  logic              pw_valid_q, pw_valid_d;
  entry_t            pw_q, pw_d;

  logic              port_req_q, port_req_d;
  logic              port_we_q, port_we_d;
  entry_t            port_q, port_d_ent;
  logic              overflow_q, overflow_d;

  logic [22:0]       wr_addr;
  logic [1:0]        byte_ds;
  entry_t            fresh, merged, enq_entry;
  logic              fifo_full, fifo_empty, pop, can_enq, issue, enq, drop, accept_wr;
  logic [CNTW-1:0]   free_cnt;

  assign wr_addr    = ioctl_addr[23:1] + ADDR_BASE;
  assign byte_ds    = ioctl_addr[0] ? 2'b10 : 2'b01;
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign free_cnt   = DEPTH_C - count_q;
  assign pop        = (rq_state_q == RQ_BUSY) && (port_ack == port_req_q);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign can_enq    = !fifo_full || pop;
  assign issue      = (rq_state_q == RQ_IDLE) && !fifo_empty && (port_req_q == port_ack);
  assign accept_wr  = (dl_state_q == DL_ACTIVE) && ioctl_wr;

  always_comb begin
    fresh.addr = wr_addr;
    fresh.ds   = byte_ds;
    fresh.data = ioctl_addr[0] ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
    merged     = pw_q;
    merged.ds  = pw_q.ds | byte_ds;
    if (ioctl_addr[0]) merged.data[15:8] = ioctl_dout;
    else               merged.data[7:0]  = ioctl_dout;
  end

  // Partial-word merge, eviction and flush; the PW is untouched when a byte is dropped.
  always_comb begin
    enq        = 1'b0;
    drop       = 1'b0;
    enq_entry  = pw_q;
    pw_valid_d = pw_valid_q;
    pw_d       = pw_q;
    if (accept_wr) begin
      if (pw_valid_q && (pw_q.addr == wr_addr)) begin
        if (merged.ds == 2'b11) begin
          if (can_enq) begin
            enq        = 1'b1;
            enq_entry  = merged;
            pw_valid_d = 1'b0;
          end else begin
            drop = 1'b1;
          end
        end else begin
          pw_d = merged;
        end
      end else if (pw_valid_q) begin
        if (can_enq) begin
          enq       = 1'b1;
          enq_entry = pw_q;
          pw_d      = fresh;
        end else begin
          drop = 1'b1;
        end
      end else begin
        pw_valid_d = 1'b1;
        pw_d       = fresh;
      end
    end else if ((dl_state_q == DL_FLUSH) && pw_valid_q && can_enq) begin
      enq        = 1'b1;
      enq_entry  = pw_q;
      pw_valid_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rq_state_d = rq_state_q;
    port_req_d = port_req_q;
    port_we_d  = 1'b0;
    port_d_ent = port_q;
    case (rq_state_q)
      RQ_IDLE: begin
        if (issue) begin
          rq_state_d = RQ_BUSY;
          port_req_d = ~port_req_q;
          port_we_d  = 1'b1;
          port_d_ent = mem_q[rd_ptr_q];
        end
      end
      RQ_BUSY: begin
        if (pop) rq_state_d = RQ_IDLE;
      end
      default: rq_state_d = RQ_IDLE;
    endcase
  end

  always_comb begin
    dl_state_d = dl_state_q;
    case (dl_state_q)
      DL_IDLE:   if (ioctl_downl)  dl_state_d = DL_ACTIVE;
      DL_ACTIVE: if (!ioctl_downl) dl_state_d = DL_FLUSH;
      DL_FLUSH:  if (!pw_valid_q && fifo_empty && (rq_state_q == RQ_IDLE)) dl_state_d = DL_DONE;
      DL_DONE:   dl_state_d = DL_IDLE;
      default:   dl_state_d = DL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      dl_state_q <= DL_IDLE;
      rq_state_q <= RQ_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pw_valid_q <= 1'b0;
      pw_q       <= '0;
      port_req_q <= 1'b0;
      port_we_q  <= 1'b0;
      port_q     <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      dl_state_q <= dl_state_d;
      rq_state_q <= rq_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pw_valid_q <= pw_valid_d;
      pw_q       <= pw_d;
      port_req_q <= port_req_d;
      port_we_q  <= port_we_d;
      port_q     <= port_d_ent;
      overflow_q <= overflow_d;
      if (enq) mem_q[wr_ptr_q] <= enq_entry;
    end
  end

  assign ioctl_wait = (free_cnt <= CNTW'(2)) || (dl_state_q == DL_FLUSH) || (dl_state_q == DL_DONE);
  assign port_req   = port_req_q;
  assign port_we    = port_we_q;
  assign port_a     = port_q.addr;
  assign port_ds    = port_q.ds;
  assign port_d     = port_q.data;
  assign done       = (dl_state_q == DL_DONE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sdram_dl_writer.sv
// Directed bench for sdram_dl_writer: packing, flush, address wrap, backpressure,
// overflow and asynchronous reset, with a toggle-ack responder and write monitor.
module tb_sdram_dl_writer;

  logic        clk = 1'b0;
  logic        init_n, ioctl_downl, ioctl_wr, port_ack, ack_en;
  logic [23:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait, port_req, port_we, done, overflow;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;

  logic        downl2, ack2;
  logic        wait2, req2, we2, done2, ovf2;
  logic [22:0] a2;
  logic [1:0]  ds2;
  logic [15:0] d2;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  wr_t  wq[$];
  int   toggles = 0;
  int   we_cycles = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  sdram_dl_writer #(.FIFO_DEPTH(4), .ADDR_BASE(23'h0)) dut (
    .clk(clk), .init_n(init_n), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .port_req(port_req), .port_ack(port_ack), .port_we(port_we), .port_a(port_a),
    .port_ds(port_ds), .port_d(port_d), .done(done), .overflow(overflow)
  );

  sdram_dl_writer #(.FIFO_DEPTH(4), .ADDR_BASE(23'h7FFFFF)) dut_wrap (
    .clk(clk), .init_n(init_n), .ioctl_downl(downl2), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(wait2),
    .port_req(req2), .port_ack(ack2), .port_we(we2), .port_a(a2),
    .port_ds(ds2), .port_d(d2), .done(done2), .overflow(ovf2)
  );

  // SDRAM controller model: answers each request toggle two negedges later.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!init_n) begin
        port_ack = 1'b0;
        cnt = 0;
      end else if (ack_en && (port_ack !== port_req)) begin
        if (cnt == 1) begin
          port_ack = port_req;
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Records every issued write of the main instance.
  initial begin
    forever begin
      @(negedge clk);
      if (!init_n) begin
        req_prev = 1'b0;
      end else begin
        if (port_we) we_cycles++;
        if (port_req !== req_prev) begin
          wq.push_back('{a: port_a, ds: port_ds, d: port_d});
          toggles++;
          req_prev = port_req;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_byte(input logic [23:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int pulses);
    pulses = 0;
    repeat (budget) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  task automatic expect_wr(input string tag, input logic [22:0] a, input logic [1:0] ds,
                           input logic [15:0] d, input logic [15:0] dmask);
    wr_t e;
    e = 'x;
    if (wq.size() > 0) e = wq.pop_front();
    check({tag, "_a"}, 32'(e.a), 32'(a));
    check({tag, "_ds"}, 32'(e.ds), 32'(ds));
    check({tag, "_d"}, 32'(e.d & dmask), 32'(d & dmask));
  endtask

  task automatic run_basic(input string tag);
    int p;
    ack_en = 1'b1;
    ioctl_downl = 1'b1;
    tick(1);
    wr_byte(24'd0, 8'h11);
    wr_byte(24'd1, 8'h22);
    check({tag, "_req_not_yet"}, 32'(port_req), 32'd0);
    tick(1);
    check({tag, "_req_toggled"}, 32'(port_req), 32'd1);
    check({tag, "_we_on_toggle"}, 32'(port_we), 32'd1);
    check({tag, "_port_a"}, 32'(port_a), 32'h0);
    check({tag, "_port_ds"}, 32'(port_ds), 32'h3);
    check({tag, "_port_d"}, 32'(port_d), 32'h2211);
    tick(1);
    check({tag, "_we_one_cycle"}, 32'(port_we), 32'd0);
    ioctl_downl = 1'b0;
    wait_done(40, p);
    check({tag, "_done_pulses"}, 32'(p), 32'd1);
    expect_wr({tag, "_w0"}, 23'h0, 2'b11, 16'h2211, 16'hFFFF);
    check({tag, "_no_extra"}, 32'(wq.size()), 32'd0);
  endtask

  initial begin
    int p, i;
    init_n = 1'b0; ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    port_ack = 1'b0; ack_en = 1'b0; downl2 = 1'b0; ack2 = 1'b0;
    tick(2);
    check("rst_req", 32'(port_req), 32'd0);
    check("rst_we", 32'(port_we), 32'd0);
    check("rst_a", 32'(port_a), 32'd0);
    check("rst_ds", 32'(port_ds), 32'd0);
    check("rst_d", 32'(port_d), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    init_n = 1'b1;
    tick(2);

    // Full word from two bytes.
    run_basic("basic");

    // Single odd byte flushed on the fall of ioctl_downl.
    ioctl_downl = 1'b1;
    tick(1);
    wr_byte(24'd5, 8'hAA);
    ioctl_downl = 1'b0;
    tick(1);
    check("flush_wait", 32'(ioctl_wait), 32'd1);
    wait_done(40, p);
    check("flush_done_pulses", 32'(p), 32'd1);
    expect_wr("flush_w", 23'h2, 2'b10, 16'hAA00, 16'hFF00);

    // Address wrap on the ADDR_BASE=7FFFFF instance, acked by hand.
    downl2 = 1'b1;
    tick(1);
    wr_byte(24'd0, 8'h01);
    wr_byte(24'd1, 8'h02);
    tick(1);
    check("wrap0_req", 32'(req2), 32'd1);
    check("wrap0_we", 32'(we2), 32'd1);
    check("wrap0_a", 32'(a2), 32'h7FFFFF);
    check("wrap0_ds", 32'(ds2), 32'h3);
    check("wrap0_d", 32'(d2), 32'h0201);
    ack2 = 1'b1;
    tick(2);
    wr_byte(24'd2, 8'h03);
    wr_byte(24'd3, 8'h04);
    tick(1);
    check("wrap1_req", 32'(req2), 32'd0);
    check("wrap1_a", 32'(a2), 32'h0);
    check("wrap1_d", 32'(d2), 32'h0403);
    ack2 = 1'b0;
    tick(2);
    downl2 = 1'b0;
    p = 0;
    repeat (10) begin
      @(negedge clk);
      if (done2) p++;
    end
    check("wrap_done_pulses", 32'(p), 32'd1);
    check("wrap_ovf", 32'(ovf2), 32'd0);
    check("wrap_wait_idle", 32'(wait2), 32'd0);

    // Backpressure honoured while acks are held back.
    ack_en = 1'b0;
    ioctl_downl = 1'b1;
    tick(1);
    i = 0;
    for (int c = 0; c < 12; c++) begin
      if (!ioctl_wait && i < 12) begin
        ioctl_addr = 24'(i); ioctl_dout = 8'(8'h30 + i); ioctl_wr = 1'b1; i++;
      end else begin
        ioctl_wr = 1'b0;
      end
      @(negedge clk);
    end
    ioctl_wr = 1'b0;
    check("bp_accepted_while_held", 32'(i), 32'd4);
    check("bp_wait_asserted", 32'(ioctl_wait), 32'd1);
    ack_en = 1'b1;
    for (int c = 0; c < 300 && i < 12; c++) begin
      if (!ioctl_wait) begin
        ioctl_addr = 24'(i); ioctl_dout = 8'(8'h30 + i); ioctl_wr = 1'b1; i++;
      end else begin
        ioctl_wr = 1'b0;
      end
      @(negedge clk);
    end
    ioctl_wr = 1'b0;
    check("bp_all_sent", 32'(i), 32'd12);
    ioctl_downl = 1'b0;
    wait_done(60, p);
    check("bp_done_pulses", 32'(p), 32'd1);
    check("bp_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 6; k++)
      expect_wr($sformatf("bp_w%0d", k), 23'(k), 2'b11,
                {8'(8'h31 + 2 * k), 8'(8'h30 + 2 * k)}, 16'hFFFF);
    check("bp_no_extra", 32'(wq.size()), 32'd0);

    // Backpressure ignored: bytes 9..11 dropped.
    ack_en = 1'b0;
    ioctl_downl = 1'b1;
    tick(1);
    for (int k = 0; k < 12; k++) wr_byte(24'(k), 8'(8'h50 + k));
    check("ovf_set", 32'(overflow), 32'd1);
    ioctl_downl = 1'b0;
    ack_en = 1'b1;
    wait_done(80, p);
    check("ovf_done_pulses", 32'(p), 32'd1);
    for (int k = 0; k < 4; k++)
      expect_wr($sformatf("ovf_w%0d", k), 23'(k), 2'b11,
                {8'(8'h51 + 2 * k), 8'(8'h50 + 2 * k)}, 16'hFFFF);
    expect_wr("ovf_flush", 23'h4, 2'b01, 16'h0058, 16'h00FF);
    check("ovf_no_extra", 32'(wq.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset while a request is outstanding.
    ack_en = 1'b0;
    ioctl_downl = 1'b1;
    tick(1);
    wr_byte(24'd0, 8'h77);
    wr_byte(24'd1, 8'h66);
    tick(1);
    check("busy_we_before_rst", 32'(port_we), 32'd1);
    #2;
    init_n = 1'b0;
    port_ack = 1'b0;
    ioctl_downl = 1'b0;
    #1;
    check("arst_req", 32'(port_req), 32'd0);
    check("arst_we", 32'(port_we), 32'd0);
    check("arst_a", 32'(port_a), 32'd0);
    check("arst_ds", 32'(port_ds), 32'd0);
    check("arst_d", 32'(port_d), 32'd0);
    check("arst_wait", 32'(ioctl_wait), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    tick(2);
    init_n = 1'b1;
    wq.delete();
    tick(2);
    run_basic("after_rst");

    check("we_per_toggle", 32'(we_cycles), 32'(toggles));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
